// File: rtl/joy_pad.sv
// -----------------------------------------------------------------------------
// joy_pad : game-pad responder for a host that strobes the select (TH) line.
//
// The host toggles pin_d7; every edge of the synchronized select advances the
// protocol phase and the phase picks which buttons are presented on the data,
// TL and TR pins (all active-low, all registered).
//
// Build option: define JOY_PAD_SIX_EN for the 8-phase six-button sequence with
// an idle timeout that restarts the phase counter. Without it the block is a
// three-button pad whose phase simply follows the select level.
//
// Ports:
//   clock            system clock (25 MHz domain)
//   reset_n          asynchronous active-low reset
//   buttons[11:0]    pressed=1, {mode,x,y,z,start,c,b,a,right,left,down,up}
//   pin_d7           select (TH) from the host, asynchronous
//   pin_d1..pin_d4   data lines D0..D3, active-low
//   pin_d6           TL line, active-low
//   pin_d9           TR line, active-low
//   phase[2:0]       current protocol phase (debug)
// -----------------------------------------------------------------------------
module joy_pad #(
    parameter int unsigned TIMEOUT = 37500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] buttons,
    input  logic        pin_d7,
    output logic        pin_d1,
    output logic        pin_d2,
    output logic        pin_d3,
    output logic        pin_d4,
    output logic        pin_d6,
    output logic        pin_d9,
    output logic [2:0]  phase
);

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned PINS_W  = 6;
    localparam int unsigned TIMER_W = 16;

    // Select synchronizer and edge detection
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sel_prev;
    logic               w_edge;

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;

    // Pin vector layout: {TR, TL, D3, D2, D1, D0}
    logic [PINS_W-1:0]  r_pins;
    logic [PINS_W-1:0]  w_pins_nxt;

    logic w_up, w_down, w_left, w_right, w_a, w_b, w_c, w_start;

    assign w_up    = buttons[0];
    assign w_down  = buttons[1];
    assign w_left  = buttons[2];
    assign w_right = buttons[3];
    assign w_a     = buttons[4];
    assign w_b     = buttons[5];
    assign w_c     = buttons[6];
    assign w_start = buttons[7];

    assign w_edge = r_sync2 ^ r_sel_prev;

`ifdef JOY_PAD_SIX_EN
    logic w_x, w_y, w_z, w_mode;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;

    assign w_z    = buttons[8];
    assign w_y    = buttons[9];
    assign w_x    = buttons[10];
    assign w_mode = buttons[11];

    // Phase counter with idle timeout; an edge always beats a same-cycle expiry
    always_comb begin
        w_phase_nxt = r_phase;
        w_timer_nxt = r_timer;
        if (w_edge) begin
            w_phase_nxt = r_phase + PHASE_W'(1);
            w_timer_nxt = '0;
        end else begin
            if (r_timer >= TIMER_W'(TIMEOUT)) begin
                w_phase_nxt = {2'b00, ~r_sync2};
            end
            if (r_timer != {TIMER_W{1'b1}}) begin
                w_timer_nxt = r_timer + TIMER_W'(1);
            end
        end
    end

    // Phase-to-pin encoding for the six-button sequence
    always_comb begin
        w_pins_nxt = {PINS_W{1'b1}};
        case (r_phase)
            3'd0, 3'd2, 3'd4: w_pins_nxt = {~w_c, ~w_b, ~w_right, ~w_left, ~w_down, ~w_up};
            3'd1, 3'd3:       w_pins_nxt = {~w_start, ~w_a, 2'b00, ~w_down, ~w_up};
            3'd5:             w_pins_nxt = {~w_start, ~w_a, 4'b0000};
            3'd6:             w_pins_nxt = {~w_c, ~w_b, ~w_mode, ~w_x, ~w_y, ~w_z};
            default:          w_pins_nxt = {~w_start, ~w_a, 4'b1111};
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_nxt;
        end
    end
`else
    // Extended buttons and timeout have no role in the three-button pad
    logic w_unused_six;
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
    assign w_unused_six = ^{buttons[11:8], w_edge};

    // Phase follows the synchronized select level
    always_comb begin
        w_phase_nxt = {2'b00, ~r_sync2};
    end

    always_comb begin
        w_pins_nxt = {PINS_W{1'b1}};
        if (r_phase[0]) begin
            w_pins_nxt = {~w_start, ~w_a, 2'b00, ~w_down, ~w_up};
        end else begin
            w_pins_nxt = {~w_c, ~w_b, ~w_right, ~w_left, ~w_down, ~w_up};
        end
    end
`endif

    // Synchronizer, phase and registered pins; reset releases all lines high
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sel_prev <= 1'b1;
            r_phase    <= '0;
            r_pins     <= {PINS_W{1'b1}};
        end else begin
            r_sync1    <= pin_d7;
            r_sync2    <= r_sync1;
            r_sel_prev <= r_sync2;
            r_phase    <= w_phase_nxt;
            r_pins     <= w_pins_nxt;
        end
    end

    assign pin_d1 = r_pins[0];
    assign pin_d2 = r_pins[1];
    assign pin_d3 = r_pins[2];
    assign pin_d4 = r_pins[3];
    assign pin_d6 = r_pins[4];
    assign pin_d9 = r_pins[5];
    assign phase  = r_phase;

endmodule
